// File: rtl/mem_pkg.sv
// Shared types and constants for the cache-to-memory port arbiter.
package mem_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int BUS_WIDTH  = 128;
  localparam int MASK_WIDTH = BUS_WIDTH / 8;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [BUS_WIDTH-1:0]  bus_data_t;
  typedef logic [MASK_WIDTH-1:0] bus_mask_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    WAIT_W = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// 128-bit memory request port; the requester side uses the master modport.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  logic      ren;
  addr_t     raddr;
  logic      wen;
  addr_t     waddr;
  bus_data_t wdata;
  bus_mask_t wmask;
  bus_data_t rdata;
  logic      rvalid;
  logic      wvalid;

  modport master (
    output ren, raddr, wen, waddr, wdata, wmask,
    input  rdata, rvalid, wvalid
  );

  modport slave (
    input  ren, raddr, wen, waddr, wdata, wmask,
    output rdata, rvalid, wvalid
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the master that did not win last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = last;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = last;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the I-cache and D-cache memory ports onto one memory port, one
// outstanding transaction at a time, routing the done pulse back to the owner.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  m0,
  mem_port_arbiter_if.slave  m1,
  mem_port_arbiter_if.master s,
  output logic               busy,
  output logic               grant_id,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic          grant_id_q, grant_id_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ren_q, s_ren_d, s_wen_q, s_wen_d;
  addr_t         s_raddr_q, s_raddr_d, s_waddr_q, s_waddr_d;
  bus_data_t     s_wdata_q, s_wdata_d;
  bus_mask_t     s_wmask_q, s_wmask_d;

  logic pick_id, pick_valid;
  logic rd_done, wr_done;

  rr_pick2 u_pick (
    .req   ({m1.ren | m1.wen, m0.ren | m0.wen}),
    .last  (grant_id_q),
    .gnt   (pick_id),
    .valid (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    s_ren_d       = s_ren_q;
    s_wen_d       = s_wen_q;
    s_raddr_d     = s_raddr_q;
    s_waddr_d     = s_waddr_q;
    s_wdata_d     = s_wdata_q;
    s_wmask_d     = s_wmask_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          busy_d     = 1'b1;
          cnt_d      = '0;
          // A write request outranks a read from the same master.
          if (pick_id ? m1.wen : m0.wen) begin
            s_wen_d   = 1'b1;
            s_waddr_d = pick_id ? m1.waddr : m0.waddr;
            s_wdata_d = pick_id ? m1.wdata : m0.wdata;
            s_wmask_d = pick_id ? m1.wmask : m0.wmask;
            state_d   = WAIT_W;
          end else begin
            s_ren_d   = 1'b1;
            s_raddr_d = pick_id ? m1.raddr : m0.raddr;
            state_d   = WAIT_R;
          end
        end
      end
      WAIT_R, WAIT_W: begin
        if (cnt_q != TMAX) cnt_d = cnt_q + CW'(1);
        // Timeout only flags the condition; the grant keeps waiting.
        if (cnt_d == TMAX) timeout_err_d = 1'b1;
        if (state_q == WAIT_R && s.rvalid) begin
          s_ren_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        if (state_q == WAIT_W && s.wvalid) begin
          s_wen_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_id_q    <= 1'b1;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      s_ren_q       <= 1'b0;
      s_wen_q       <= 1'b0;
      s_raddr_q     <= '0;
      s_waddr_q     <= '0;
      s_wdata_q     <= '0;
      s_wmask_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
      s_ren_q       <= s_ren_d;
      s_wen_q       <= s_wen_d;
      s_raddr_q     <= s_raddr_d;
      s_waddr_q     <= s_waddr_d;
      s_wdata_q     <= s_wdata_d;
      s_wmask_q     <= s_wmask_d;
    end
  end

  assign rd_done = (state_q == WAIT_R) && s.rvalid;
  assign wr_done = (state_q == WAIT_W) && s.wvalid;

  assign m0.rvalid = rd_done && !grant_id_q;
  assign m1.rvalid = rd_done &&  grant_id_q;
  assign m0.wvalid = wr_done && !grant_id_q;
  assign m1.wvalid = wr_done &&  grant_id_q;
  assign m0.rdata  = m0.rvalid ? s.rdata : '0;
  assign m1.rdata  = m1.rvalid ? s.rdata : '0;

  assign s.ren   = s_ren_q;
  assign s.wen   = s_wen_q;
  assign s.raddr = s_raddr_q;
  assign s.waddr = s_waddr_q;
  assign s.wdata = s_wdata_q;
  assign s.wmask = s_wmask_q;

  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic clk;
  logic rst;
  logic busy, grant_id, timeout_err;
  int   checks;
  int   errors;

  localparam bus_data_t RD_A5  = {16{8'hA5}};
  localparam bus_data_t RD_B   = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam bus_data_t WPAT   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam bus_mask_t ONES_M = '1;

  mem_port_arbiter_if m0_if ();
  mem_port_arbiter_if m1_if ();
  mem_port_arbiter_if s_if ();

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if.slave),
    .m1          (m1_if.slave),
    .s           (s_if.master),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after another unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    m0_if.ren = 0; m0_if.raddr = '0; m0_if.wen = 0; m0_if.waddr = '0; m0_if.wdata = '0; m0_if.wmask = '0;
    m1_if.ren = 0; m1_if.raddr = '0; m1_if.wen = 0; m1_if.waddr = '0; m1_if.wdata = '0; m1_if.wmask = '0;
    s_if.rdata = '0; s_if.rvalid = 0; s_if.wvalid = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_grant_id", grant_id, 1);
    check_val("rst_s_ren", s_if.ren, 0);
    check_val("rst_s_wen", s_if.wen, 0);
    check_val("rst_terr", timeout_err, 0);
    check_val("rst_s_raddr", s_if.raddr, 0);
    $display("txn reset: busy=%0d grant_id=%0d", busy, grant_id);

    // Single read from m0, slave answers 3 cycles after s_ren.
    step(); m0_if.ren = 1; m0_if.raddr = 64'h1000; #1;
    step(); #1;
    check_val("rd_s_ren", s_if.ren, 1);
    check_val("rd_s_raddr", s_if.raddr, 64'h1000);
    check_val("rd_busy", busy, 1);
    check_val("rd_grant", grant_id, 0);
    step(); s_if.wvalid = 1; #1;
    check_val("stray_w_m0_wvalid", m0_if.wvalid, 0);
    check_val("stray_w_m0_rvalid", m0_if.rvalid, 0);
    step(); s_if.wvalid = 0; #1;
    check_val("stray_w_s_ren_held", s_if.ren, 1);
    check_val("stray_w_busy_held", busy, 1);
    step(); s_if.rvalid = 1; s_if.rdata = RD_A5; #1;
    check_val("rd_m0_rvalid", m0_if.rvalid, 1);
    check_val("rd_m0_rdata", m0_if.rdata, RD_A5);
    check_val("rd_m1_rvalid", m1_if.rvalid, 0);
    check_val("rd_m1_rdata", m1_if.rdata, 0);
    step(); s_if.rvalid = 0; m0_if.ren = 0; #1;
    check_val("rd_m0_rvalid_end", m0_if.rvalid, 0);
    check_val("rd_busy_end", busy, 0);
    check_val("rd_s_ren_end", s_if.ren, 0);
    $display("txn single_read: rdata=%h", RD_A5);

    // Stray read valid while idle.
    step(); s_if.rvalid = 1; #1;
    check_val("stray_r_m0_rvalid", m0_if.rvalid, 0);
    check_val("stray_r_m1_rvalid", m1_if.rvalid, 0);
    step(); s_if.rvalid = 0; #1;
    check_val("stray_r_busy", busy, 0);
    check_val("stray_r_s_ren", s_if.ren, 0);
    $display("txn stray_valid_idle");

    // Tie after reset: m0 read first, then m1 write, then tie goes to m0 again.
    rst = 1; step(); rst = 0;
    m0_if.ren = 1; m0_if.raddr = 64'h3000;
    m1_if.wen = 1; m1_if.waddr = 64'h2010; m1_if.wdata = WPAT; m1_if.wmask = ONES_M; #1;
    step(); #1;
    check_val("tie_grant_m0", grant_id, 0);
    check_val("tie_s_ren", s_if.ren, 1);
    check_val("tie_s_wen", s_if.wen, 0);
    check_val("tie_s_raddr", s_if.raddr, 64'h3000);
    step(); s_if.rvalid = 1; s_if.rdata = RD_B; #1;
    check_val("tie_m0_rvalid", m0_if.rvalid, 1);
    check_val("tie_m0_rdata", m0_if.rdata, RD_B);
    check_val("tie_m1_wvalid", m1_if.wvalid, 0);
    step(); s_if.rvalid = 0; m0_if.ren = 0; #1;
    check_val("tie_idle_busy", busy, 0);
    check_val("tie_idle_s_wen", s_if.wen, 0);
    step(); m0_if.ren = 1; #1;
    check_val("wr_s_wen", s_if.wen, 1);
    check_val("wr_grant_m1", grant_id, 1);
    check_val("wr_s_waddr", s_if.waddr, 64'h2010);
    check_val("wr_s_wdata", s_if.wdata, WPAT);
    check_val("wr_s_wmask", s_if.wmask, ONES_M);
    step(); s_if.rvalid = 1; #1;
    check_val("wr_stray_m1_rvalid", m1_if.rvalid, 0);
    check_val("wr_stray_m1_wvalid", m1_if.wvalid, 0);
    step(); s_if.rvalid = 0; #1;
    check_val("wr_hold_s_wen", s_if.wen, 1);
    check_val("wr_hold_s_wdata", s_if.wdata, WPAT);
    step(); s_if.wvalid = 1; #1;
    check_val("wr_m1_wvalid", m1_if.wvalid, 1);
    check_val("wr_m0_wvalid", m0_if.wvalid, 0);
    step(); s_if.wvalid = 0; #1;
    check_val("wr_m1_wvalid_end", m1_if.wvalid, 0);
    check_val("wr_busy_end", busy, 0);
    step(); #1;
    check_val("tie2_grant_m0", grant_id, 0);
    check_val("tie2_s_ren", s_if.ren, 1);
    check_val("tie2_s_wen", s_if.wen, 0);
    step(); s_if.rvalid = 1; m1_if.wen = 0; #1;
    check_val("tie2_m0_rvalid", m0_if.rvalid, 1);
    step(); s_if.rvalid = 0; m0_if.ren = 0; #1;
    check_val("tie2_terr", timeout_err, 0);
    $display("txn tie_rr: m0 read, m1 write, m0 read");

    // Timeout with TIMEOUT=8: slave silent for 8 WAIT cycles.
    step(); m1_if.ren = 1; m1_if.raddr = 64'h4000; #1;
    step(); #1;
    check_val("to_grant_m1", grant_id, 1);
    for (int i = 0; i < 7; i++) step();
    #1;
    check_val("to_terr_before", timeout_err, 0);
    step(); #1;
    check_val("to_terr_set", timeout_err, 1);
    check_val("to_still_busy", busy, 1);
    step(); s_if.rvalid = 1; s_if.rdata = RD_A5; #1;
    check_val("to_m1_rvalid", m1_if.rvalid, 1);
    step(); s_if.rvalid = 0; m1_if.ren = 0; #1;
    check_val("to_busy_end", busy, 0);
    step(); #1;
    check_val("to_terr_sticky", timeout_err, 1);
    $display("txn timeout: timeout_err=%0d", timeout_err);

    // Asynchronous reset in the middle of a read.
    step(); m0_if.ren = 1; m0_if.raddr = 64'h5000; #1;
    step(); #1;
    check_val("mid_s_ren", s_if.ren, 1);
    #2; rst = 1; #1;
    check_val("mid_rst_s_ren", s_if.ren, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_terr", timeout_err, 0);
    check_val("mid_rst_grant", grant_id, 1);
    step(); rst = 0; m0_if.ren = 0; #1;
    step(); s_if.rvalid = 1; #1;
    check_val("mid_late_m0_rvalid", m0_if.rvalid, 0);
    check_val("mid_late_busy", busy, 0);
    step(); s_if.rvalid = 0; #1;
    $display("txn reset_mid_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-master, one-slave arbiter placed directly downstream of the cache CMUs. It merges the I-cache and D-cache 128-bit memory request ports onto the single memory port (DDR2 MIG side). It registers one transaction at a time, holds the grant until the slave returns its valid pulse, and routes the response back to the requesting master.

Parameters:
ADDR_WIDTH, 64, byte address width on all ports
BUS_WIDTH, 128, memory data width (two 64-bit cache words)
TIMEOUT, 1024, cycles a granted transaction may wait for a slave valid before timeout_err is set

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
mX_ren (X=0,1)  in  1  read request, held until mX_rvalid
mX_raddr  in  ADDR_WIDTH  read address, 16-byte aligned
mX_wen  in  1  write request, held until mX_wvalid
mX_waddr  in  ADDR_WIDTH  write address, 16-byte aligned
mX_wdata  in  BUS_WIDTH  write data
mX_wmask  in  BUS_WIDTH/8  byte write mask
mX_rdata  out  BUS_WIDTH  read data, valid only with mX_rvalid
mX_rvalid  out  1  one-cycle read-done pulse
mX_wvalid  out  1  one-cycle write-done pulse
s_ren / s_wen  out  1  slave read / write request
s_raddr / s_waddr  out  ADDR_WIDTH  slave addresses
s_wdata  out  BUS_WIDTH  slave write data
s_wmask  out  BUS_WIDTH/8  slave write mask
s_rdata  in  BUS_WIDTH  slave read data
s_rvalid / s_wvalid  in  1  slave one-cycle done pulses
busy  out  1  1 while a transaction is granted
grant_id  out  1  master that owns the current or last grant
timeout_err  out  1  sticky timeout flag

Behaviour:
- One clock; reset is asynchronous and active-high. Reset values: state IDLE; s_ren, s_wen, busy, timeout_err, all mX_rvalid/mX_wvalid = 0; s_* addresses, data and mask = 0; grant_id = 1, so master 0 wins the first tie.
- States:
  - IDLE: sample requests; reqX = mX_ren | mX_wen.
    - Only one master requesting: grant it.
    - Both requesting: grant the master != grant_id (round-robin).
    - Within one master, wen beats ren.
    - On a grant edge: latch address, data and mask into the s_* registers; set s_wen or s_ren = 1; set busy = 1; update grant_id; go to WAIT_W or WAIT_R. First slave request is visible 1 cycle after the master's request is sampled.
  - WAIT_R: hold all s_* outputs stable.
    - When s_rvalid = 1: m[grant_id]_rvalid = 1 combinationally in the same cycle and m[grant_id]_rdata = s_rdata.
    - On that edge: s_ren <= 0, busy <= 0, go to IDLE.
  - WAIT_W: same as WAIT_R, using s_wvalid and m[grant_id]_wvalid; s_wen <= 0 on exit.
- The non-granted master never sees a valid pulse; its mX_rdata is driven 0.
- IDLE lasts at least 1 cycle between transactions, so back-to-back requests from one master are spaced by 1 cycle.
- Stray s_rvalid/s_wvalid in IDLE, or the wrong-kind valid in a WAIT state, is ignored (no master pulse, no state change).
- A master deasserting its request while granted does not abort the transaction; it completes to the slave and the response pulse is still generated.
- Timeout:
  - A latency counter clears on grant and increments each WAIT cycle, saturating at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err, which is sticky until rst.
  - The state is not changed; the arbiter keeps waiting.
- Reset mid-transaction: all outputs go to reset values immediately; a late slave valid after reset is ignored per the rule above.
- Addresses are passed through unmodified; no alignment checking.

Decomposition:
- Shared package mem_pkg: BUS_WIDTH constant, typedefs addr_t / bus_data_t / bus_mask_t, arbiter state enum {IDLE, WAIT_R, WAIT_W}.
- One natural sub-module: rr_pick2 (2-way round-robin picker: req[1:0] + last grant in -> grant index + valid out), purely combinational.

Test Plan:
- Single read: m0_ren=1, raddr=0x1000; slave returns rvalid 3 cycles after s_ren with s_rdata=0xA5..A5 -> s_raddr=0x1000 one cycle after request; m0_rvalid pulses 1 cycle with rdata=0xA5..A5; m1_rvalid stays 0.
- Simultaneous requests after reset: m0_ren and m1_wen both asserted -> m0 granted first; m1 write issued after m0 rvalid plus 1 IDLE cycle; the next tie goes to m0 again, since grant_id=1 after m1.
- Write: m1_wen, waddr=0x2010, wmask=all ones, wdata=pattern -> s_wen=1 with identical fields held stable until s_wvalid; m1_wvalid pulses once.
- Stray valid: s_rvalid pulse in IDLE and s_wvalid during WAIT_R -> no master valid, state unchanged.
- Timeout: TIMEOUT=8, slave never responds -> timeout_err=1 after 8 WAIT cycles and stays 1 after a later response completes.
- Reset mid-WAIT_R: assert rst -> s_ren=0 and busy=0 immediately; a later s_rvalid produces no m0_rvalid.
